// File: rtl/wb_regfile.sv
// Integer register file x0..x31 with per-register in-flight write scoreboard.
// Optional same-cycle write-back bypass on the read ports: define REGFILE_BYPASS_EN.

// One scoreboard counter: tracks outstanding writers of a single rd.
module wb_sb_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec_wb,
   input  logic             dec_kill,
   output logic [CNT_W-1:0] cnt,
   output logic             pend,
   output logic             err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W:0] up, diff, dn;
   logic           under, over;

   always_comb begin
      up    = {1'b0, cnt} + (CNT_W+1)'(inc);
      dn    = (CNT_W+1)'(dec_wb) + (CNT_W+1)'(dec_kill);
      diff  = up - dn;
      under = up < dn;
      // diff can only reach 2**CNT_W, so its top bit flags overflow
      over  = ~under & diff[CNT_W];
      err   = under | over;
`ifdef REGFILE_BYPASS_EN
      pend  = {1'b0, cnt} > dn;
`else
      pend  = cnt != '0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt <= '0;
      else if (under) cnt <= '0;
      else if (over)  cnt <= CNT_MAX;
      else            cnt <= diff[CNT_W-1:0];
   end
endmodule

module wb_regfile #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      wb_rd_idx_i,
   input  logic            wb_rd_wren_i,
   input  logic [XLEN-1:0] wb_rd_data_i,
   input  logic [4:0]      id_rs1_idx_i,
   input  logic [4:0]      id_rs2_idx_i,
   output logic [XLEN-1:0] id_rs1_data_o,
   output logic [XLEN-1:0] id_rs2_data_o,
   input  logic            iss_valid_i,
   input  logic            iss_rd_wren_i,
   input  logic [4:0]      iss_rd_idx_i,
   input  logic            kill_valid_i,
   input  logic [4:0]      kill_rd_idx_i,
   output logic            stall_o,
   output logic            sb_err_o
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [31:0][XLEN-1:0]  regs;
   logic [31:0][CNT_W-1:0] cnt;
   logic [31:0]            pend, err_v;
   logic                   wb_hit, kill_hit, iss_hit;

   assign wb_hit   = wb_rd_wren_i & (wb_rd_idx_i != 5'd0);
   assign kill_hit = kill_valid_i & (kill_rd_idx_i != 5'd0);
   assign iss_hit  = iss_valid_i & iss_rd_wren_i & (iss_rd_idx_i != 5'd0) & ~stall_o;

   // x0 has no counter: never pending, never in error
   assign cnt[0]   = '0;
   assign pend[0]  = 1'b0;
   assign err_v[0] = 1'b0;

   for (genvar r = 1; r < 32; r++) begin : g_sb
      wb_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .inc      (iss_hit  & (iss_rd_idx_i  == 5'(r))),
         .dec_wb   (wb_hit   & (wb_rd_idx_i   == 5'(r))),
         .dec_kill (kill_hit & (kill_rd_idx_i == 5'(r))),
         .cnt      (cnt[r]),
         .pend     (pend[r]),
         .err      (err_v[r])
      );
   end

   // regs[0] is reset and never written, so it reads as constant zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         regs <= '0;
      else if (wb_hit) regs[wb_rd_idx_i] <= wb_rd_data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         sb_err_o <= 1'b0;
      else if (|err_v) sb_err_o <= 1'b1;
   end

   always_comb begin
      id_rs1_data_o = regs[id_rs1_idx_i];
      id_rs2_data_o = regs[id_rs2_idx_i];
`ifdef REGFILE_BYPASS_EN
      if (wb_hit && wb_rd_idx_i == id_rs1_idx_i) id_rs1_data_o = wb_rd_data_i;
      if (wb_hit && wb_rd_idx_i == id_rs2_idx_i) id_rs2_data_o = wb_rd_data_i;
`endif
   end

   // Independent of iss_valid_i so ID's valid never loops back through stall
   assign stall_o = (pend[id_rs1_idx_i] & (id_rs1_idx_i != 5'd0))
                  | (pend[id_rs2_idx_i] & (id_rs2_idx_i != 5'd0))
                  | ((cnt[iss_rd_idx_i] == CNT_MAX) & iss_rd_wren_i & (iss_rd_idx_i != 5'd0));
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_wb_regfile;
   localparam int XLEN = 64;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk, rst;
   logic [4:0]      wb_rd_idx, id_rs1_idx, id_rs2_idx, iss_rd_idx, kill_rd_idx;
   logic            wb_rd_wren, iss_valid, iss_rd_wren, kill_valid;
   logic [XLEN-1:0] wb_rd_data, id_rs1_data, id_rs2_data;
   logic            stall, sb_err;

   wb_regfile #(.XLEN(XLEN), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .wb_rd_idx_i(wb_rd_idx), .wb_rd_wren_i(wb_rd_wren), .wb_rd_data_i(wb_rd_data),
      .id_rs1_idx_i(id_rs1_idx), .id_rs2_idx_i(id_rs2_idx),
      .id_rs1_data_o(id_rs1_data), .id_rs2_data_o(id_rs2_data),
      .iss_valid_i(iss_valid), .iss_rd_wren_i(iss_rd_wren), .iss_rd_idx_i(iss_rd_idx),
      .kill_valid_i(kill_valid), .kill_rd_idx_i(kill_rd_idx),
      .stall_o(stall), .sb_err_o(sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string           nm;
      logic [XLEN-1:0] d1, d2;
      logic            st, er;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   vectors = 0;
   int   miscompares = 0;

   always @(negedge clk) begin
      while (q.size() > 0) begin
         bit bad;
         m = q.pop_front();
         vectors++;
         bad = 1'b0;
         if (id_rs1_data !== m.d1) begin
            $display("FAIL %s rs1_data got %h exp %h", m.nm, id_rs1_data, m.d1); bad = 1'b1;
         end
         if (id_rs2_data !== m.d2) begin
            $display("FAIL %s rs2_data got %h exp %h", m.nm, id_rs2_data, m.d2); bad = 1'b1;
         end
         if (stall !== m.st) begin
            $display("FAIL %s stall got %b exp %b", m.nm, stall, m.st); bad = 1'b1;
         end
         if (sb_err !== m.er) begin
            $display("FAIL %s sb_err got %b exp %b", m.nm, sb_err, m.er); bad = 1'b1;
         end
         if (bad) miscompares++;
      end
   end

   task automatic idle();
      wb_rd_idx = '0; wb_rd_wren = 1'b0; wb_rd_data = '0;
      id_rs1_idx = '0; id_rs2_idx = '0;
      iss_valid = 1'b0; iss_rd_wren = 1'b0; iss_rd_idx = '0;
      kill_valid = 1'b0; kill_rd_idx = '0;
   endtask

   // Called at posedge+1 with inputs already applied; expectation is for this cycle
   task automatic vec(input string nm, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                      input logic es, input logic ee);
      exp_t e;
      e.nm = nm; e.d1 = e1; e.d2 = e2; e.st = es; e.er = ee;
      q.push_back(e);
      @(posedge clk); #1;
      idle();
   endtask

   task automatic issue(input logic [4:0] rd);
      iss_valid = 1'b1; iss_rd_wren = 1'b1; iss_rd_idx = rd;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
      wb_rd_wren = 1'b1; wb_rd_idx = rd; wb_rd_data = d;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state: every register reads zero, nothing pending
      for (int i = 0; i < 16; i++) begin
         id_rs1_idx = 5'(i); id_rs2_idx = 5'(i + 16);
         vec("rst_rd", '0, '0, 1'b0, 1'b0);
      end

      // write x5 (owned by an issued instruction) and x0
      issue(5'd5);                          vec("iss5", '0, '0, 1'b0, 1'b0);
      wb(5'd5, 64'hDEAD_BEEF);              vec("wb5", '0, '0, 1'b0, 1'b0);
      wb(5'd0, 64'h1234);
      id_rs1_idx = 5'd5; id_rs2_idx = 5'd0; vec("rd5_x0", 64'hDEAD_BEEF, '0, 1'b0, 1'b0);
      id_rs1_idx = 5'd0; id_rs2_idx = 5'd0; vec("x0_zero", '0, '0, 1'b0, 1'b0);

      // RAW on x7
      issue(5'd7);                          vec("iss7", '0, '0, 1'b0, 1'b0);
      id_rs1_idx = 5'd7;                    vec("raw7_a", '0, '0, 1'b1, 1'b0);
      id_rs1_idx = 5'd7;                    vec("raw7_b", '0, '0, 1'b1, 1'b0);
      wb(5'd7, 64'h55); id_rs1_idx = 5'd7;
      vec("wb7", BYP ? 64'h55 : 64'h0, '0, !BYP, 1'b0);
      id_rs1_idx = 5'd7;                    vec("rd7", 64'h55, '0, 1'b0, 1'b0);

      // fill x3 counter to max, fourth issue blocked
      for (int i = 0; i < 3; i++) begin
         issue(5'd3);                       vec("iss3", '0, '0, 1'b0, 1'b0);
      end
      issue(5'd3);                          vec("iss3_full", '0, '0, 1'b1, 1'b0);
      issue(5'd3);                          vec("iss3_hold", '0, '0, 1'b1, 1'b0);
      issue(5'd3); wb(5'd3, 64'h33);        vec("wb3", '0, '0, 1'b1, 1'b0);
      iss_rd_wren = 1'b1; iss_rd_idx = 5'd3; vec("stall3_clr", '0, '0, 1'b0, 1'b0);

      // issue + wb + kill on x9 with cnt=2 nets to 1
      issue(5'd9);                          vec("iss9_a", '0, '0, 1'b0, 1'b0);
      issue(5'd9);                          vec("iss9_b", '0, '0, 1'b0, 1'b0);
      issue(5'd9); wb(5'd9, 64'h99); kill_valid = 1'b1; kill_rd_idx = 5'd9;
      vec("iss_wb_kill9", '0, '0, 1'b0, 1'b0);
      id_rs1_idx = 5'd9;                    vec("cnt9_1", 64'h99, '0, 1'b1, 1'b0);
      kill_valid = 1'b1; kill_rd_idx = 5'd9; id_rs1_idx = 5'd9;
      vec("kill9", 64'h99, '0, !BYP, 1'b0);
      id_rs1_idx = 5'd9;                    vec("cnt9_0", 64'h99, '0, 1'b0, 1'b0);

      // write-back with nothing outstanding flags underflow
      wb(5'd4, 64'h44);                     vec("wb4_nocnt", '0, '0, 1'b0, 1'b0);
      id_rs1_idx = 5'd4;                    vec("rd4_err", 64'h44, '0, 1'b0, 1'b1);
      vec("err_sticky", '0, '0, 1'b0, 1'b1);

      // reset mid-stall clears everything without waiting for an edge
      issue(5'd10);                         vec("iss10", '0, '0, 1'b0, 1'b1);
      id_rs1_idx = 5'd10;                   vec("stall10", '0, '0, 1'b1, 1'b1);
      id_rs1_idx = 5'd10; rst = 1'b1;       vec("rst_mid", '0, '0, 1'b0, 1'b0);
      id_rs1_idx = 5'd5; id_rs2_idx = 5'd4; vec("rst_hold", '0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      id_rs1_idx = 5'd5; id_rs2_idx = 5'd4; vec("post_rst", '0, '0, 1'b0, 1'b0);

      @(negedge clk); #1;
      if (q.size() != 0) begin
         $display("FAIL drain queue got %0d exp 0", q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
